req_channel: RTL and testbench

//  Consumer end of the request-ID presentation interface. One instance per output channel (ch0, ch1).
//  - Raises ready when it can take a request.
//  - Captures req_id on the cycle req_id_valid is high.
//  - Emits a fixed-length response packet for that ID on an AXI-Stream master.
//  - Holds ready low until the packet's last beat has been accepted.

---
 rtl/req_channel_pkg.sv | 16 +
 rtl/req_channel.sv | 104 ++++++++++
 tb/tb_req_channel.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/req_channel_pkg.sv
// req_channel_pkg: FSM encoding and beat field widths shared by the response channel.
package req_channel_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int CH_ID_W    = 8;
  localparam int BEAT_IDX_W = 16;

  function automatic int beat_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_channel.sv
// req_channel: captures a presented request ID and answers it with a fixed-length AXI-Stream packet.
module req_channel
  import req_channel_pkg::*;
#(
  parameter int REQ_ID_WIDTH = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int RSP_BEATS    = 4,
  parameter int CH_ID        = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    req_id_valid,
  input  logic [REQ_ID_WIDTH-1:0] req_id,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   AXIS_TDATA,
  output logic                    AXIS_TVALID,
  output logic                    AXIS_TLAST,
  input  logic                    AXIS_TREADY,
  output logic [31:0]             rsp_count
);

  localparam int BW = beat_w(RSP_BEATS);
  localparam logic [BW-1:0] LAST = BW'(RSP_BEATS - 1);

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [REQ_ID_WIDTH-1:0] id_q, id_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [31:0]             rsp_count_q, rsp_count_d;
  logic                    capture, hs, hs_last;
  logic [BEAT_IDX_W-1:0]   next_idx;

  // ready is registered, so capture never loops combinationally through req_id_valid
  assign capture  = (state_q == ST_IDLE) && ready_q && req_id_valid;
  assign hs       = (state_q == ST_SEND) && tvalid_q && AXIS_TREADY;
  assign hs_last  = hs && (beat_q == LAST);
  assign next_idx = BEAT_IDX_W'(beat_q) + BEAT_IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    beat_d      = beat_q;
    id_d        = id_q;
    tdata_d     = tdata_q;
    rsp_count_d = rsp_count_q;
    if (state_q == ST_IDLE) begin
      ready_d = enable && !capture;
      if (capture) begin
        state_d  = ST_SEND;
        id_d     = req_id;
        beat_d   = '0;
        tvalid_d = 1'b1;
        tlast_d  = (RSP_BEATS == 1);
        tdata_d  = DATA_WIDTH'({CH_ID_W'(CH_ID), req_id});
      end
    end else if (hs_last) begin
      state_d     = ST_IDLE;
      ready_d     = enable;
      tvalid_d    = 1'b0;
      tlast_d     = 1'b0;
      tdata_d     = '0;
      rsp_count_d = rsp_count_q + 32'd1;
    end else if (hs) begin
      beat_d  = beat_q + BW'(1);
      tlast_d = (next_idx == BEAT_IDX_W'(RSP_BEATS - 1));
      tdata_d = DATA_WIDTH'({id_q, next_idx});
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      beat_q      <= '0;
      id_q        <= '0;
      tdata_q     <= '0;
      rsp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      beat_q      <= beat_d;
      id_q        <= id_d;
      tdata_q     <= tdata_d;
      rsp_count_q <= rsp_count_d;
    end
  end

  assign ready       = ready_q;
  assign AXIS_TVALID = tvalid_q;
  assign AXIS_TLAST  = tlast_q;
  assign AXIS_TDATA  = tdata_q;
  assign rsp_count   = rsp_count_q;

endmodule

// File: tb/tb_req_channel.sv
// tb_req_channel: directed scenarios for req_channel with RSP_BEATS=4, CH_ID=1.
module tb_req_channel;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic        req_id_valid = 1'b0;
  logic [31:0] req_id = '0;
  logic        ready;
  logic [63:0] AXIS_TDATA;
  logic        AXIS_TVALID;
  logic        AXIS_TLAST;
  logic        AXIS_TREADY = 1'b0;
  logic [31:0] rsp_count;

  int n_cmp = 0;
  int n_err = 0;

  req_channel #(
    .REQ_ID_WIDTH(32),
    .DATA_WIDTH(64),
    .RSP_BEATS(4),
    .CH_ID(1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .req_id_valid(req_id_valid),
    .req_id(req_id),
    .ready(ready),
    .AXIS_TDATA(AXIS_TDATA),
    .AXIS_TVALID(AXIS_TVALID),
    .AXIS_TLAST(AXIS_TLAST),
    .AXIS_TREADY(AXIS_TREADY),
    .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_beat(input logic [31:0] id, input int k);
    logic [31:0] kk;
    kk = k;
    return (k == 0) ? {24'h0, 8'h01, id} : {16'h0, id, kk[15:0]};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || AXIS_TVALID !== 1'b0 || AXIS_TLAST !== 1'b0 || AXIS_TDATA !== 64'h0 || rsp_count !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b v=%b l=%b d=%h cnt=%0d, want all zero", ready, AXIS_TVALID, AXIS_TLAST, AXIS_TDATA, rsp_count);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || AXIS_TVALID !== 1'b0 || rsp_count !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b v=%b cnt=%0d, want rdy=1 v=0 cnt=0", ready, AXIS_TVALID, rsp_count);
    end
  endtask

  task automatic test_packet();
    AXIS_TREADY = 1'b1;
    req_id = 32'h0000_00A5;
    req_id_valid = 1'b1;
    @(negedge clk);
    req_id_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== exp_beat(32'hA5, k) || AXIS_TLAST !== (k == 3) || ready !== 1'b0) begin
        n_err++;
        $display("FAIL packet_beat%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=0", k, AXIS_TVALID, AXIS_TDATA, AXIS_TLAST, ready, exp_beat(32'hA5, k), k == 3);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (AXIS_TVALID !== 1'b0 || ready !== 1'b1 || rsp_count !== 32'd1) begin
      n_err++;
      $display("FAIL packet_done: got v=%b rdy=%b cnt=%0d, want v=0 rdy=1 cnt=1", AXIS_TVALID, ready, rsp_count);
    end
  endtask

  task automatic test_backpressure();
    int n;
    AXIS_TREADY = 1'b0;
    req_id = 32'h1234_5678;
    req_id_valid = 1'b1;
    @(negedge clk);
    req_id_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      n_cmp++;
      if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== exp_beat(32'h1234_5678, n) || AXIS_TLAST !== (n == 3) || ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_beat%0d_cyc%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=0", n, c, AXIS_TVALID, AXIS_TDATA, AXIS_TLAST, ready, exp_beat(32'h1234_5678, n), n == 3);
      end
      AXIS_TREADY = (c % 2 == 0);
      if (AXIS_TREADY) n++;
      @(negedge clk);
    end
    AXIS_TREADY = 1'b0;
    n_cmp++;
    if (AXIS_TVALID !== 1'b0 || ready !== 1'b1 || rsp_count !== 32'd2) begin
      n_err++;
      $display("FAIL backpressure_done: got v=%b rdy=%b cnt=%0d, want v=0 rdy=1 cnt=2", AXIS_TVALID, ready, rsp_count);
    end
  endtask

  task automatic test_ignore_valid();
    AXIS_TREADY = 1'b1;
    req_id = 32'hDEAD_BEEF;
    req_id_valid = 1'b1;
    @(negedge clk);
    req_id = 32'h5555_AAAA;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== exp_beat(32'hDEAD_BEEF, k) || AXIS_TLAST !== (k == 3)) begin
        n_err++;
        $display("FAIL ignore_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b", k, AXIS_TVALID, AXIS_TDATA, AXIS_TLAST, exp_beat(32'hDEAD_BEEF, k), k == 3);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (AXIS_TVALID !== 1'b0 || ready !== 1'b1 || rsp_count !== 32'd3) begin
      n_err++;
      $display("FAIL ignore_done: got v=%b rdy=%b cnt=%0d, want v=0 rdy=1 cnt=3", AXIS_TVALID, ready, rsp_count);
    end
    req_id_valid = 1'b0;
  endtask

  task automatic test_enable();
    AXIS_TREADY = 1'b1;
    req_id = 32'h0000_0042;
    req_id_valid = 1'b1;
    @(negedge clk);
    req_id_valid = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== exp_beat(32'h42, k) || AXIS_TLAST !== (k == 3)) begin
        n_err++;
        $display("FAIL enable_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b", k, AXIS_TVALID, AXIS_TDATA, AXIS_TLAST, exp_beat(32'h42, k), k == 3);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (AXIS_TVALID !== 1'b0 || ready !== 1'b0 || rsp_count !== 32'd4) begin
      n_err++;
      $display("FAIL enable_done: got v=%b rdy=%b cnt=%0d, want v=0 rdy=0 cnt=4", AXIS_TVALID, ready, rsp_count);
    end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL enable_hold_low: got rdy=%b, want 0", ready);
    end
    enable = 1'b1;
    req_id = 32'h0000_0077;
    req_id_valid = 1'b1;
    @(negedge clk);
    req_id_valid = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || AXIS_TVALID !== 1'b0) begin
      n_err++;
      $display("FAIL enable_rise_no_capture: got rdy=%b v=%b, want rdy=1 v=0", ready, AXIS_TVALID);
    end
  endtask

  task automatic test_reset_mid_packet();
    AXIS_TREADY = 1'b1;
    req_id = 32'h0000_0077;
    req_id_valid = 1'b1;
    @(negedge clk);
    req_id_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== exp_beat(32'h77, 2)) begin
      n_err++;
      $display("FAIL midreset_beat2: got v=%b d=%h, want v=1 d=%h", AXIS_TVALID, AXIS_TDATA, exp_beat(32'h77, 2));
    end
    #1 resetn = 1'b0;
    #1;
    n_cmp++;
    if (AXIS_TVALID !== 1'b0 || AXIS_TLAST !== 1'b0 || ready !== 1'b0 || rsp_count !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_async: got v=%b l=%b rdy=%b cnt=%0d, want all zero", AXIS_TVALID, AXIS_TLAST, ready, rsp_count);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || AXIS_TVALID !== 1'b0 || rsp_count !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_release: got rdy=%b v=%b cnt=%0d, want rdy=1 v=0 cnt=0", ready, AXIS_TVALID, rsp_count);
    end
    req_id = 32'h0000_0099;
    req_id_valid = 1'b1;
    @(negedge clk);
    req_id_valid = 1'b0;
    n_cmp++;
    if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== exp_beat(32'h99, 0) || AXIS_TLAST !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_restart: got v=%b d=%h l=%b, want v=1 d=%h l=0", AXIS_TVALID, AXIS_TDATA, AXIS_TLAST, exp_beat(32'h99, 0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_packet();
    test_backpressure();
    test_ignore_valid();
    test_enable();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
